pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Issue controller and hazard scoreboard for the 4-stage (IF/ID/EX/WB) 8-bit pipeline with 4 registers. It sits between the decode stage and the rest of the pipeline. It decides each cycle whether the decoded instruction issues to EX or stalls in place. It also sequences run, single-step and halt, and keeps issue and stall statistics.

## Interface
- CNT_W, 16, width of the saturating issue and stall counters
- clk  in  1  pipeline clock
- reset  in  1  reset, asynchronous, active-high; clock clk
- start  in  1  pulse; begin free-running execution from PC 0
- step  in  1  pulse; issue exactly one instruction, then return to IDLE
- dec_valid  in  1  decode stage holds a valid instruction
- dec_instr  in  8  decoded word: [7:6] opcode (00 ADD, 01 SUB, 10 LOAD, 11 HALT), [5:4] rd, [3:2] rs1, [1:0] rs2
- wb_valid  in  1  writeback stage retires an instruction this cycle
- wb_rd  in  2  register written by the retiring instruction
- fetch_en  out  1  IF may fetch and advance the PC (combinational)
- stall  out  1  hold IF/ID registers and inject a bubble into EX (combinational)
- issue  out  1  decode instruction moves to EX this cycle (combinational)
- pc_clear  out  1  registered one-cycle pulse; PC and IF/ID valid are cleared
- busy_mask  out  4  scoreboard; bit n=1 means a write to Rn is in flight
- state  out  3  IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4
- halted  out  1  state==HALTED
- issue_cnt  out  CNT_W  instructions issued since last start
- stall_cnt  out  CNT_W  stall cycles since last start

## Operation
- Source registers:
  - ADD and SUB read rs1 and rs2.
  - LOAD reads rs2 only.
  - HALT reads nothing and writes nothing.
- hazard = dec_valid & opcode!=HALT & (busy_mask[src] for any source, or busy_mask[rd]). The WAW check is on rd.
- Hazard checks use the registered busy_mask only. There is no same-cycle bypass from wb_valid, because the register file writes at the edge.
- active = state is RUN or STEP.
- issue = active & dec_valid & opcode!=HALT & !hazard.
- stall = active & dec_valid & hazard.
- fetch_en = active & !stall & !(dec_valid & opcode==HALT).
- Scoreboard update at each edge:
  - A retire with wb_valid clears bit wb_rd.
  - An issue sets bit rd.
  - If both target the same bit in the same cycle, set wins.
- State transitions:
  - IDLE: start -> RUN with pc_clear. step -> STEP with no pc_clear; the pipeline continues from its current PC. If start and step are asserted together, start wins.
  - RUN: dec_valid & opcode==HALT -> DRAIN.
  - STEP: first issue -> IDLE. A HALT in decode -> DRAIN.
  - DRAIN: busy_mask==0 -> HALTED. Fetch is disabled and issue stays 0. HALT remains in decode.
  - HALTED: start -> RUN with pc_clear. step is ignored.
  - start and step are ignored in RUN, STEP and DRAIN.
- Counters:
  - issue_cnt +1 per issue cycle; stall_cnt +1 per stall cycle.
  - Both saturate at 2^CNT_W-1.
  - Both clear in the cycle pc_clear is asserted.

## Timing
- Reset values: state=IDLE, busy_mask=0, pc_clear=0, halted=0, issue_cnt=0, stall_cnt=0. fetch_en, stall and issue are 0 because state is IDLE.
- Reset asserted mid-operation clears everything immediately, independent of clk. Any in-flight scoreboard bits are discarded.
- start sampled at edge N: state=RUN and pc_clear=1 during cycle N+1; pc_clear=0 from N+2.
- issue at edge N: busy_mask[rd]=1 from N+1. The instruction retires 2 cycles later (EX, then WB). A dependent instruction in decode therefore stalls for 2 cycles back-to-back and issues on the third.
- wb_valid at edge N clears the bit from N+1. Decode may issue in cycle N+1.
- DRAIN -> HALTED one edge after busy_mask reads 0. halted rises in the same cycle as state=HALTED.
- Outputs issue, stall and fetch_en depend combinationally on state, busy_mask, dec_valid and dec_instr only. They never depend on wb inputs.

## Test plan
- Reset and start: after reset, all outputs are 0 and state=0. Pulse start: state=1 and pc_clear=1 for exactly one cycle; fetch_en=1 afterwards.
- RAW stall: issue ADD R1,R2,R3 (0x1B), then SUB R2,R1,R0 (0x64) in decode next cycle -> stall=1 for 2 cycles while busy_mask=4'b0010. wb_valid with wb_rd=1 clears it; SUB issues next cycle; issue_cnt=2, stall_cnt=2.
- LOAD source rule: busy_mask=4'b0100, LOAD R0,R2(rs1),R1 (0x89) -> issue=1 with no stall (rs1 ignored). LOAD R0,R0,R2 (0x82) -> stall=1.
- Halt and drain: HALT (0xC0) in decode with busy_mask=4'b1000 -> state=DRAIN, fetch_en=0, issue=0. Retire R3 -> HALTED next edge and halted=1. start -> RUN with counters cleared.
- Single step: from IDLE, pulse step with ADD (0x1B) in decode -> exactly one issue, state returns to 0, fetch_en=0 afterwards; issue_cnt=1.
- Boundary checks: set and clear of the same bit in one cycle -> bit stays 1. Assert reset during DRAIN -> state=IDLE and busy_mask=0 immediately. Drive stall for 2^CNT_W+3 cycles (CNT_W=4) -> stall_cnt holds at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Issue control, hazard scoreboard and run/step/halt sequencing
// for the 4-stage 8-bit pipeline.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic             dec_valid,
  input  logic [7:0]       dec_instr,
  input  logic             wb_valid,
  input  logic [1:0]       wb_rd,
  output logic             fetch_en,
  output logic             stall,
  output logic             issue,
  output logic             pc_clear,
  output logic [3:0]       busy_mask,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4
  } state_e;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  state_e           state_q, state_d;
  logic [3:0]       busy_q, busy_d;
  logic             pc_clear_q, pc_clear_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [1:0] opcode;
  logic [1:0] rd;
  logic [1:0] rs1;
  logic [1:0] rs2;
  logic       is_halt;
  logic       src_busy;
  logic       hazard;
  logic       active;
  logic       halt_in_dec;

  assign opcode  = dec_instr[7:6];
  assign rd      = dec_instr[5:4];
  assign rs1     = dec_instr[3:2];
  assign rs2     = dec_instr[1:0];
  assign is_halt = (opcode == OP_HALT);

  // LOAD addresses through rs2 only; rs1 is a don't-care field
  always_comb begin
    src_busy = 1'b0;
    unique case (opcode)
      OP_ADD,
      OP_SUB:  src_busy = busy_q[rs1] | busy_q[rs2];
      OP_LOAD: src_busy = busy_q[rs2];
      OP_HALT: src_busy = 1'b0;
      default: src_busy = 1'b0;
    endcase
  end

  assign hazard = dec_valid & ~is_halt
                & (src_busy | busy_q[rd]);
  assign halt_in_dec = dec_valid & is_halt;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start)     state_d = S_RUN;
        else if (step) state_d = S_STEP;
      end
      S_RUN: begin
        if (halt_in_dec) state_d = S_DRAIN;
      end
      S_STEP: begin
        if (halt_in_dec) state_d = S_DRAIN;
        else if (issue)  state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (busy_q == 4'b0000) state_d = S_HALTED;
      end
      S_HALTED: begin
        if (start) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    active     = (state_q == S_RUN)
               | (state_q == S_STEP);
    halted     = (state_q == S_HALTED);
    pc_clear_d = start & ((state_q == S_IDLE)
               | (state_q == S_HALTED));
    issue      = active & dec_valid
               & ~is_halt & ~hazard;
    stall      = active & dec_valid & hazard;
    fetch_en   = active & ~stall & ~halt_in_dec;
  end

  // Set wins over a same-cycle retire of the same register
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_rd] = 1'b0;
    if (issue)    busy_d[rd]    = 1'b1;
  end

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (pc_clear_d) begin
      issue_cnt_d = '0;
      stall_cnt_d = '0;
    end else begin
      if (issue && issue_cnt_q != '1)
        issue_cnt_d = issue_cnt_q + CNT_W'(1);
      if (stall && stall_cnt_q != '1)
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q      <= 4'b0000;
      pc_clear_q  <= 1'b0;
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      busy_q      <= busy_d;
      pc_clear_q  <= pc_clear_d;
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pc_clear  = pc_clear_q;
  assign busy_mask = busy_q;
  assign state     = state_q;
  assign issue_cnt = issue_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl.
// Inputs change on negedge; outputs sampled before the next posedge.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             step;
  logic             dec_valid;
  logic [7:0]       dec_instr;
  logic             wb_valid;
  logic [1:0]       wb_rd;
  logic             fetch_en;
  logic             stall;
  logic             issue;
  logic             pc_clear;
  logic [3:0]       busy_mask;
  logic [2:0]       state;
  logic             halted;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .step      (step),
    .dec_valid (dec_valid),
    .dec_instr (dec_instr),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .fetch_en  (fetch_en),
    .stall     (stall),
    .issue     (issue),
    .pc_clear  (pc_clear),
    .busy_mask (busy_mask),
    .state     (state),
    .halted    (halted),
    .issue_cnt (issue_cnt),
    .stall_cnt (stall_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    step      = 1'b0;
    dec_valid = 1'b0;
    dec_instr = 8'h00;
    wb_valid  = 1'b0;
    wb_rd     = 2'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_state", state, 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_pcclr", pc_clear, 0);
    chk("rst_halted", halted, 0);
    chk("rst_icnt", issue_cnt, 0);
    chk("rst_scnt", stall_cnt, 0);
    chk("rst_fetch", fetch_en, 0);
    chk("rst_stall", stall, 0);
    chk("rst_issue", issue, 0);

    // start
    @(negedge clk);
    start = 1'b1;
    cyc();
    start = 1'b0;
    #1;
    chk("start_state", state, 1);
    chk("start_pcclr", pc_clear, 1);
    chk("start_fetch", fetch_en, 1);
    cyc();
    chk("start_pcclr0", pc_clear, 0);

    // RAW: ADD R1,R2,R3 then SUB R2,R1,R0
    dec_valid = 1'b1;
    dec_instr = 8'h1B;
    #1;
    chk("add_issue", issue, 1);
    cyc();
    dec_instr = 8'h64;
    #1;
    chk("raw_stall1", stall, 1);
    chk("raw_issue1", issue, 0);
    chk("raw_busy", busy_mask, 4'b0010);
    chk("raw_fetch", fetch_en, 0);
    cyc();
    #1;
    chk("raw_stall2", stall, 1);
    wb_valid = 1'b1;
    wb_rd    = 2'd1;
    #1;
    chk("wb_no_bypass", stall, 1);
    cyc();
    wb_valid = 1'b0;
    #1;
    chk("raw_busy_clr", busy_mask, 0);
    chk("sub_issue", issue, 1);
    chk("sub_stall", stall, 0);
    cyc();
    dec_valid = 1'b0;
    #1;
    chk("raw_icnt", issue_cnt, 2);
    chk("raw_scnt", stall_cnt, 2);
    chk("raw_busy2", busy_mask, 4'b0100);

    // LOAD source rule with R2 busy
    dec_valid = 1'b1;
    dec_instr = 8'h82;
    #1;
    chk("load_rs2_stall", stall, 1);
    dec_instr = 8'h89;
    #1;
    chk("load_rs1_issue", issue, 1);
    chk("load_rs1_stall", stall, 0);
    cyc();
    chk("load_busy", busy_mask, 4'b0101);
    chk("load_icnt", issue_cnt, 3);

    // Issue R3 while retiring R3: set wins
    dec_instr = 8'h35;
    wb_valid  = 1'b1;
    wb_rd     = 2'd3;
    #1;
    chk("sc_issue", issue, 1);
    cyc();
    dec_valid = 1'b0;
    chk("set_wins", busy_mask, 4'b1101);
    wb_rd = 2'd0;
    cyc();
    wb_rd = 2'd2;
    cyc();
    wb_valid = 1'b0;
    chk("busy_r3", busy_mask, 4'b1000);

    // HALT and drain
    dec_valid = 1'b1;
    dec_instr = 8'hC0;
    #1;
    chk("halt_fetch_run", fetch_en, 0);
    chk("halt_issue_run", issue, 0);
    cyc();
    chk("drain_state", state, 3);
    chk("drain_fetch", fetch_en, 0);
    chk("drain_issue", issue, 0);
    wb_valid = 1'b1;
    wb_rd    = 2'd3;
    cyc();
    wb_valid = 1'b0;
    chk("drain_busy0", busy_mask, 0);
    chk("drain_hold", state, 3);
    chk("drain_halted", halted, 0);
    cyc();
    chk("halted_state", state, 4);
    chk("halted_flag", halted, 1);
    step = 1'b1;
    cyc();
    step = 1'b0;
    chk("halted_step", state, 4);
    dec_valid = 1'b0;
    start     = 1'b1;
    cyc();
    start = 1'b0;
    chk("restart_state", state, 1);
    chk("restart_pcclr", pc_clear, 1);
    chk("restart_icnt", issue_cnt, 0);
    chk("restart_scnt", stall_cnt, 0);

    // Reset during DRAIN
    dec_valid = 1'b1;
    dec_instr = 8'h1B;
    cyc();
    dec_instr = 8'hC0;
    cyc();
    chk("drain2_state", state, 3);
    chk("drain2_busy", busy_mask, 4'b0010);
    #2;
    reset = 1'b1;
    #1;
    chk("async_state", state, 0);
    chk("async_busy", busy_mask, 0);
    chk("async_icnt", issue_cnt, 0);
    @(negedge clk);
    reset = 1'b0;

    // Single step
    dec_instr = 8'h1B;
    step      = 1'b1;
    #1;
    chk("idle_issue", issue, 0);
    cyc();
    step = 1'b0;
    chk("step_state", state, 2);
    chk("step_issue", issue, 1);
    cyc();
    chk("step_back", state, 0);
    chk("step_issue0", issue, 0);
    chk("step_fetch0", fetch_en, 0);
    cyc();
    chk("step_icnt", issue_cnt, 1);
    chk("step_busy", busy_mask, 4'b0010);
    dec_valid = 1'b0;

    // Stall saturation, R1 still busy
    start = 1'b1;
    cyc();
    start     = 1'b0;
    dec_valid = 1'b1;
    dec_instr = 8'h64;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("sat_mid", stall_cnt, 10);
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("sat_hold", stall_cnt, 15);
    chk("sat_icnt", issue_cnt, 0);
    dec_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
